// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel coordinates, syncs, active flag and frame strobe.
// Optional 8-bit frame counter port enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // One extra bit so a window ending exactly at 2048/1024 does not truncate.
  localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic        hs_next;
  logic        vs_next;
  logic        act_next;
  logic        fs_next;

  // Decode works on the post-increment counts so the registered flags line up with them.
  always_comb begin
    h_wrap   = (hcount == H_LAST);
    v_wrap   = (vcount == V_LAST);
    h_next   = h_wrap ? '0 : hcount + 11'd1;
    v_next   = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + 10'd1;
    end
    h_ext    = {1'b0, h_next};
    v_ext    = {1'b0, v_next};
    hs_next  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
    vs_next  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
    act_next = (h_ext < H_VIS) && (v_ext < V_VIS);
    fs_next  = h_wrap && v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      active      <= act_next;
      frame_start <= fs_next;
    end else begin
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_en && fs_next) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: reduced raster instance plus a default-timing instance.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int SH_A = 8;
  localparam int SH_F = 2;
  localparam int SH_S = 4;
  localparam int SH_B = 2;
  localparam int SV_A = 6;
  localparam int SV_F = 1;
  localparam int SV_S = 2;
  localparam int SV_B = 1;
  localparam int HT    = SH_A + SH_F + SH_S + SH_B;
  localparam int VT    = SV_A + SV_F + SV_S + SV_B;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic d_en = 1'b0;

  logic [10:0] s_h, d_h;
  logic [9:0]  s_v, d_v;
  logic        s_hs, s_vs, s_act, s_fs;
  logic        d_hs, d_vs, d_act, d_fs;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0]  s_fc, d_fc;
`endif

  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .frame_start(s_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_sync_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_en(d_en),
    .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .frame_start(d_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  obs_t m_exp;
  obs_t s_obs;
  int   m_h;
  int   m_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic obs_t small_dec(input int h, input int v, input logic fs);
    obs_t o;
    o.h   = 11'(h);
    o.v   = 10'(v);
    o.hs  = (h >= SH_A + SH_F && h < SH_A + SH_F + SH_S) ? 1'b0 : 1'b1;
    o.vs  = (v >= SV_A + SV_F && v < SV_A + SV_F + SV_S) ? 1'b1 : 1'b0;
    o.act = (h < SH_A) && (v < SV_A);
    o.fs  = fs;
    return o;
  endfunction

  function automatic obs_t s_snap();
    return {s_h, s_v, s_hs, s_vs, s_act, s_fs};
  endfunction

  function automatic obs_t d_snap();
    return {d_h, d_v, d_hs, d_vs, d_act, d_fs};
  endfunction

  task automatic model_reset();
    m_h   = HT - 1;
    m_v   = VT - 1;
    m_exp = small_dec(HT - 1, VT - 1, 1'b0);
  endtask

  task automatic step(input logic en, input string tag);
    logic fs;
    pix_en = en;
    if (en) begin
      fs = (m_h == HT - 1) && (m_v == VT - 1);
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
      m_exp = small_dec(m_h, m_v, fs);
    end else begin
      m_exp.fs = 1'b0;
    end
    exp_q.push_back(m_exp);
    @(posedge clk);
    #1;
    s_obs = s_snap();
    check(tag, 64'(s_obs), 64'(exp_q.pop_front()));
  endtask

  initial begin
    int   n;
    int   h;
    int   v;
    obs_t dexp;
`ifdef VGA_SYNC_FRAME_CNT_EN
    int   fsn;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_default", 64'(d_snap()), 64'({11'd1055, 10'd627, 1'b0, 1'b0, 1'b0, 1'b0}));
    model_reset();
    check("rst_small", 64'(s_snap()), 64'(m_exp));
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("rst_frame_cnt", 64'(s_fc), 64'(8'd0));
`endif
    #2 rst_n = 1'b1;

    // Default 800x600 timing: one full line plus the wrap into line 1.
    for (int k = 1; k <= 1057; k++) begin
      d_en = 1'b1;
      @(posedge clk);
      #1;
      h        = (k - 1) % 1056;
      v        = (k - 1) / 1056;
      dexp.h   = 11'(h);
      dexp.v   = 10'(v);
      dexp.hs  = (h >= 840) && (h < 968);
      dexp.vs  = 1'b0;
      dexp.act = (h < 800);
      dexp.fs  = (k == 1);
      check((k == 1) ? "first_default" : "line_default", 64'(d_snap()), 64'(dexp));
    end
    d_en = 1'b0;

    step(1'b1, "first_small");
    check("first_fs", 64'(s_obs.fs), 64'(1'b1));
    step(1'b1, "second_small");

    n = 1;
    do begin
      step(1'b1, "frame_small");
      n++;
    end while (!s_obs.fs && n < 2000);
    check("frame_period", 64'(n), 64'(FRAME));

    n = 0;
    do begin
      step((n % 2) == 1, "toggle_small");
      n++;
    end while (!s_obs.fs && n < 4000);
    check("toggle_period", 64'(n), 64'(2 * FRAME));
    step(1'b0, "toggle_hold");
    check("fs_width", 64'(s_obs.fs), 64'(1'b0));

    n = 0;
    while (!(m_h == 5 && m_v == 3) && n < 2000) begin
      step(1'b1, "run_small");
      n++;
    end
    check("reach_mid", 64'({m_h == 5, m_v == 3}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_small", 64'(s_snap()), 64'(m_exp));
    check("rst_mid_default", 64'(d_snap()), 64'({11'd1055, 10'd627, 1'b0, 1'b0, 1'b0, 1'b0}));
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_small", 64'(s_snap()), 64'(m_exp));
    #2 rst_n = 1'b1;
    step(1'b1, "restart_small");
    check("restart_fs", 64'(s_obs.fs), 64'(1'b1));

`ifdef VGA_SYNC_FRAME_CNT_EN
    fsn = 1;
    n   = 0;
    while (fsn < 257 && n < 257 * FRAME + 100) begin
      step(1'b1, "fc_run");
      n++;
      if (s_obs.fs) fsn++;
    end
    check("fc_frames", 64'(fsn), 64'(257));
    check("frame_cnt_wrap", 64'(s_fc), 64'(8'd1));
`endif

    pix_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. Produces the `hcount`/`vcount` pixel coordinates consumed by the colour generators, along with the hsync/vsync pulses, the active-video flag and a frame-start strobe. Default timing is 800x600@60 Hz (40 MHz pixel rate). All outputs are registered and mutually aligned in the same cycle.

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, hsync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vsync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HS_POL`, 1, hsync active level
- `VS_POL`, 1, vsync active level

Ports:
- `clk` input 1: system clock; one clock, all state on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pix_en` input 1: pixel-clock enable; the raster advances one pixel per cycle in which it is high.
- `hcount` output 11: horizontal position, 0..H_TOTAL-1.
- `vcount` output 10: vertical position, 0..V_TOTAL-1.
- `hsync` output 1: horizontal sync, active level `HS_POL`.
- `vsync` output 1: vertical sync, active level `VS_POL`.
- `active` output 1: high when (`hcount`, `vcount`) is inside the visible area.
- `frame_start` output 1: one-cycle strobe on entry to (0,0).
- `frame_cnt` output 8: frame counter; present only with `VGA_SYNC_FRAME_CNT_EN`.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
  - Both must fit the port widths: H_TOTAL ≤ 2048, V_TOTAL ≤ 1024.
- Horizontal counter, on cycles where `pix_en`=1:
  - `hcount` increments by 1.
  - At H_TOTAL-1 it wraps to 0, and `vcount` advances.
- Vertical counter: at V_TOTAL-1, `vcount` wraps to 0 together with the `hcount` wrap.
- `pix_en`=0: all outputs hold, except `frame_start`, which is forced to 0.
- Decode, computed from the next counter values and registered so that it is aligned with the counts:
  - `hsync` = `HS_POL` when H_ACTIVE+H_FP ≤ `hcount` < H_ACTIVE+H_FP+H_SYNC, else ~`HS_POL`.
  - `vsync` = `VS_POL` when V_ACTIVE+V_FP ≤ `vcount` < V_ACTIVE+V_FP+V_SYNC, else ~`VS_POL`.
  - `active` = (`hcount` < H_ACTIVE) && (`vcount` < V_ACTIVE).
  - `frame_start` = 1 exactly in the cycle the counts become (0,0) from (H_TOTAL-1, V_TOTAL-1).
- Reset state:
  - `hcount`=H_TOTAL-1, `vcount`=V_TOTAL-1.
  - `hsync`=~`HS_POL`, `vsync`=~`VS_POL`, `active`=0, `frame_start`=0.
  - This is a consistent back-porch position, so the first `pix_en` after reset enters (0,0) and raises `frame_start`.
- Reset mid-frame: all outputs return to the reset values asynchronously; no partial-line recovery.

## Timing
- Latency is one cycle: the `pix_en` sample at edge N is reflected in all outputs after edge N.
- All outputs change together; there is no combinational path from inputs to outputs.
- hsync pulse: exactly H_SYNC enabled cycles per line.
- vsync pulse: exactly V_SYNC×H_TOTAL enabled cycles per frame.
  - vsync edges coincide with `hcount`=0.
- `frame_start` is high for exactly 1 clk cycle per frame, regardless of the `pix_en` duty cycle.
- Frame period: H_TOTAL×V_TOTAL = 663168 enabled cycles.

## Configuration
- Macro: `VGA_SYNC_FRAME_CNT_EN`.
- Defined:
  - `frame_cnt` [7:0] port exists.
  - Resets to 0, increments in the same cycle `frame_start` rises, wraps 255→0.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset then `pix_en`=1 continuously:
  - First enabled edge gives `hcount`=0, `vcount`=0, `frame_start`=1, `active`=1.
  - Next cycle `frame_start`=0.
- Line timing, `hcount` sweep:
  - `active` falls at `hcount`=800.
  - `hsync`=1 for `hcount`=840..967.
  - `hcount` wraps 1055→0 and `vcount` increments.
- Frame timing:
  - `vsync`=1 for `vcount`=601..604.
  - `active`=0 for `vcount`≥600.
  - Next `frame_start` exactly 663168 enabled cycles after the first.
- `pix_en` toggled 1,0,1,0:
  - Counters advance only on enabled cycles.
  - Full frame takes 1326336 clk cycles.
  - `frame_start` is still one clk wide.
- Assert `rst_n`=0 at `hcount`=500, `vcount`=300:
  - Outputs go immediately to 1055/627/inactive syncs/`active`=0.
  - Restart produces `frame_start`.
- With `VGA_SYNC_FRAME_CNT_EN`: run 257 frames; `frame_cnt` reads 1 after the 257th `frame_start`, confirming the 255→0 wrap.
